// File: rtl/bbox_finder.sv
`default_nettype none
// ============================================================================
//  Module      : bbox_finder
//  Description : Scans a stored 24-bit image (one colour byte per address,
//                address = y*WIDTH*3 + x*3 + c) and computes the bounding box
//                of all dark pixels, i.e. pixels whose three-channel sum is
//                at or below THRESH.
//  Ports       : clk, rst_n      - clock, synchronous active-low reset
//                start           - begin a scan (accepted in IDLE or DONE)
//                done / busy     - result valid / scan in progress
//                readAddr        - image memory address (1-cycle read latency)
//                readdata        - memory data, only [7:0] used
//                found           - a dark pixel was seen in the last scan
//                xMin..yMax      - bounding box (full image when none found)
//  Revision    : 1.0 - initial release
// ============================================================================
module bbox_finder #(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int THRESH = 384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  output logic        busy,
  output logic [23:0] readAddr,
  input  logic [15:0] readdata,
  output logic        found,
  output logic [10:0] xMin,
  output logic [10:0] xMax,
  output logic [10:0] yMin,
  output logic [10:0] yMax
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_LAT  = 3'd2;
  localparam logic [2:0] S_EVAL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [10:0] C_X_LAST = 11'(WIDTH - 1);
  localparam logic [10:0] C_Y_LAST = 11'(HEIGHT - 1);
  localparam logic [9:0]  C_THR    = 10'(THRESH);
  localparam logic [23:0] C_ROW    = 24'(WIDTH * 3);

  logic [2:0]  state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [1:0]  c_q, c_d;
  logic [9:0]  sum_q, sum_d;
  logic        first_q, first_d;
  // running box, only meaningful once first_q has cleared
  logic [10:0] bx0_q, bx0_d, bx1_q, bx1_d, by0_q, by0_d, by1_q, by1_d;
  // published result, changes only on entry to DONE or reset
  logic        found_q, found_d;
  logic [10:0] ox0_q, ox0_d, ox1_q, ox1_d, oy0_q, oy0_d, oy1_q, oy1_d;

  logic w_last;
  logic w_fg;

  assign w_last = (x_q == C_X_LAST) && (y_q == C_Y_LAST);
  assign w_fg   = (sum_q <= C_THR);

  assign readAddr = 24'(y_q) * C_ROW + 24'(x_q) * 24'd3 + {22'd0, c_q};

  assign found = found_q;
  assign xMin  = ox0_q;
  assign xMax  = ox1_q;
  assign yMin  = oy0_q;
  assign yMax  = oy1_q;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RD;
      S_RD:           state_d = S_LAT;
      S_LAT:          state_d = (c_q == 2'd2) ? S_EVAL : S_RD;
      S_EVAL:         state_d = w_last ? S_DONE : S_RD;
      default:        state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RD, S_LAT, S_EVAL: busy = 1'b1;
      S_DONE:              done = 1'b1;
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    sum_d   = sum_q;
    first_d = first_q;
    bx0_d   = bx0_q;
    bx1_d   = bx1_q;
    by0_d   = by0_q;
    by1_d   = by1_q;
    found_d = found_q;
    ox0_d   = ox0_q;
    ox1_d   = ox1_q;
    oy0_d   = oy0_q;
    oy1_d   = oy1_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          x_d     = 11'd0;
          y_d     = 11'd0;
          c_d     = 2'd0;
          sum_d   = 10'd0;
          first_d = 1'b1;
        end
      end
      S_LAT: begin
        sum_d = sum_q + {2'b00, readdata[7:0]};
        c_d   = (c_q == 2'd2) ? 2'd0 : c_q + 2'd1;
      end
      S_EVAL: begin
        if (w_fg) begin
          if (first_q) begin
            bx0_d = x_q;
            bx1_d = x_q;
            by0_d = y_q;
            by1_d = y_q;
          end else begin
            if (x_q < bx0_q) bx0_d = x_q;
            if (x_q > bx1_q) bx1_d = x_q;
            if (y_q < by0_q) by0_d = y_q;
            if (y_q > by1_q) by1_d = y_q;
          end
          first_d = 1'b0;
        end
        sum_d = 10'd0;
        if (x_q == C_X_LAST) begin
          x_d = 11'd0;
          y_d = y_q + 11'd1;
        end else begin
          x_d = x_q + 11'd1;
        end
        // Publish using the box that already includes this final pixel.
        if (w_last) begin
          found_d = ~first_d;
          if (first_d) begin
            ox0_d = 11'd0;
            ox1_d = C_X_LAST;
            oy0_d = 11'd0;
            oy1_d = C_Y_LAST;
          end else begin
            ox0_d = bx0_d;
            ox1_d = bx1_d;
            oy0_d = by0_d;
            oy1_d = by1_d;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q     <= 11'd0;
      y_q     <= 11'd0;
      c_q     <= 2'd0;
      sum_q   <= 10'd0;
      first_q <= 1'b1;
      bx0_q   <= 11'd0;
      bx1_q   <= 11'd0;
      by0_q   <= 11'd0;
      by1_q   <= 11'd0;
      found_q <= 1'b0;
      ox0_q   <= 11'd0;
      ox1_q   <= C_X_LAST;
      oy0_q   <= 11'd0;
      oy1_q   <= C_Y_LAST;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      first_q <= first_d;
      bx0_q   <= bx0_d;
      bx1_q   <= bx1_d;
      by0_q   <= by0_d;
      by1_q   <= by1_d;
      found_q <= found_d;
      ox0_q   <= ox0_d;
      ox1_q   <= ox1_d;
      oy0_q   <= oy0_d;
      oy1_q   <= oy1_d;
    end
  end

endmodule
`default_nettype wire
